taillight_sequencer: RTL



---
 rtl/taillight_pkg.sv | 48 ++++
 rtl/taillight_sequencer_step_tick_gen.sv | 30 +++
 rtl/taillight_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/taillight_pkg.sv
// Shared types and lamp patterns for the Thunderbird-style taillight sequencer.
package taillight_pkg;

    typedef enum logic [3:0] {
        IDLE,
        L1,
        L2,
        L3,
        R1,
        R2,
        R3,
        HAZ_ON,
        HAZ_OFF
    } state_t;

    typedef enum logic [1:0] {
        NONE,
        LEFT,
        RIGHT,
        HAZ
    } req_t;

    localparam logic [2:0] LAMP_OFF = 3'b000;
    localparam logic [2:0] LAMP_1   = 3'b001;
    localparam logic [2:0] LAMP_2   = 3'b011;
    localparam logic [2:0] LAMP_3   = 3'b111;

    function automatic logic [2:0] left_pattern(input state_t s);
        case (s)
            L1:      left_pattern = LAMP_1;
            L2:      left_pattern = LAMP_2;
            L3:      left_pattern = LAMP_3;
            HAZ_ON:  left_pattern = LAMP_3;
            default: left_pattern = LAMP_OFF;
        endcase
    endfunction

    function automatic logic [2:0] right_pattern(input state_t s);
        case (s)
            R1:      right_pattern = LAMP_1;
            R2:      right_pattern = LAMP_2;
            R3:      right_pattern = LAMP_3;
            HAZ_ON:  right_pattern = LAMP_3;
            default: right_pattern = LAMP_OFF;
        endcase
    endfunction

endpackage

// File: rtl/taillight_sequencer_step_tick_gen.sv
// Step-rate enable generator: one-cycle tick every DIVIDE cycles while running.
module step_tick_gen #(
    parameter int DIVIDE = 1000000,
    parameter int CNT_W  = $clog2(DIVIDE)
) (
    input  logic in_clock,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDE - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    // A step that has started always runs to its tick, even if run drops,
    // so a short request glitch still produces exactly one tick.
    always_ff @(posedge in_clock) begin
        if (reset) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else if (run || (count != '0)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/taillight_sequencer.sv
// Six-lamp Thunderbird taillight sequencer paced by an internal step tick.
// Optional brake override is enabled with `define TAILLIGHT_BRAKE_EN.
module taillight_sequencer
    import taillight_pkg::*;
#(
    parameter int DIVIDE = 1000000
) (
    input  logic       in_clock,
    input  logic       reset,
    input  logic       left_req,
    input  logic       right_req,
    input  logic       hazard_req,
`ifdef TAILLIGHT_BRAKE_EN
    input  logic       brake_req,
`endif
    output logic [2:0] lamp_l,
    output logic [2:0] lamp_r,
    output logic       step_tick
);

    localparam int CNT_W = $clog2(DIVIDE);

    state_t     state_q;
    state_t     state_d;
    req_t       req;
    logic       run;
    logic [2:0] lamp_l_q;
    logic [2:0] lamp_r_q;

    always_comb begin
        req = NONE;
        if (hazard_req || (left_req && right_req)) begin
            req = HAZ;
        end else if (left_req) begin
            req = LEFT;
        end else if (right_req) begin
            req = RIGHT;
        end
    end

    assign run = !((state_q == IDLE) && (req == NONE));

    step_tick_gen #(
        .DIVIDE (DIVIDE),
        .CNT_W  (CNT_W)
    ) u_tick (
        .in_clock (in_clock),
        .reset    (reset),
        .run      (run),
        .tick     (step_tick)
    );

    always_comb begin
        state_d = state_q;
        if (step_tick) begin
            case (state_q)
                IDLE: begin
                    case (req)
                        LEFT:    state_d = L1;
                        RIGHT:   state_d = R1;
                        HAZ:     state_d = HAZ_ON;
                        default: state_d = IDLE;
                    endcase
                end
                L1:      state_d = (req == HAZ) ? HAZ_ON : (req == LEFT)  ? L2 : IDLE;
                L2:      state_d = (req == HAZ) ? HAZ_ON : (req == LEFT)  ? L3 : IDLE;
                L3:      state_d = (req == HAZ) ? HAZ_ON : IDLE;
                R1:      state_d = (req == HAZ) ? HAZ_ON : (req == RIGHT) ? R2 : IDLE;
                R2:      state_d = (req == HAZ) ? HAZ_ON : (req == RIGHT) ? R3 : IDLE;
                R3:      state_d = (req == HAZ) ? HAZ_ON : IDLE;
                HAZ_ON:  state_d = HAZ_OFF;
                HAZ_OFF: state_d = (req == HAZ) ? HAZ_ON : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Lamps are registered from the next state so they change on the step edge.
    always_ff @(posedge in_clock) begin
        if (reset) begin
            state_q  <= IDLE;
            lamp_l_q <= LAMP_OFF;
            lamp_r_q <= LAMP_OFF;
        end else begin
            state_q  <= state_d;
            lamp_l_q <= left_pattern(state_d);
            lamp_r_q <= right_pattern(state_d);
        end
    end

`ifdef TAILLIGHT_BRAKE_EN
    logic left_seq;
    logic right_seq;

    assign left_seq  = (state_q == L1) || (state_q == L2) || (state_q == L3);
    assign right_seq = (state_q == R1) || (state_q == R2) || (state_q == R3);

    // Brake lights every side that is not showing a turn sequence.
    assign lamp_l = lamp_l_q | ((brake_req && !left_seq)  ? LAMP_3 : LAMP_OFF);
    assign lamp_r = lamp_r_q | ((brake_req && !right_seq) ? LAMP_3 : LAMP_OFF);
`else
    assign lamp_l = lamp_l_q;
    assign lamp_r = lamp_r_q;
`endif

endmodule
